// File: rtl/pattern_match_counter.sv
// Serial pattern detector with wrapping match counter and hex 7-segment drive.
// Optional runtime-loadable pattern when PATTERN_LOAD_EN is defined.
module pattern_match_counter #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                 NBITS_COUNT = 4,
  parameter bit                 OVERLAP     = 1'b1
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_bit,
  input  logic                   clear,
`ifdef PATTERN_LOAD_EN
  input  logic                   pat_load,
  input  logic [PAT_LEN-1:0]     pat_in,
`endif
  output logic                   match,
  output logic [NBITS_COUNT-1:0] count,
  output logic                   overflow,
  output logic [7:0]             seg
);

  localparam int HW = PAT_LEN - 1;
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(HW);

  logic [HW-1:0]          hist_q, hist_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic                   match_q, match_d;
  logic [NBITS_COUNT-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [PAT_LEN-1:0]     pat;
  logic [PAT_LEN-1:0]     shifted;
  logic                   ld;
  logic                   acc;
  logic                   hit;
  logic [6:0]             glyph;

`ifdef PATTERN_LOAD_EN
  logic [PAT_LEN-1:0] pat_q;
  assign pat = pat_q;
  assign ld  = pat_load;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) pat_q <= PATTERN;
    else if (pat_load) pat_q <= pat_in;
  end
`else
  assign pat = PATTERN;
  assign ld  = 1'b0;
`endif

  // A load cycle swallows the incoming bit and restarts the history.
  assign shifted = {hist_q, in_bit};
  assign acc     = in_valid && !ld;
  assign hit     = acc && (fill_q == FULL) && (shifted == pat);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = hit;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (ld) begin
      fill_d = '0;
    end else if (acc) begin
      hist_d = shifted[HW-1:0];
      if (hit && !OVERLAP) fill_d = '0;
      else if (fill_q != FULL) fill_d = fill_q + 1'b1;
    end
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hit) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    glyph = 7'h3F;
    unique case (cnt_q[3:0])
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h58;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
    endcase
  end

  assign match    = match_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign seg      = {ovf_q, glyph};

endmodule

// File: tb/tb_pattern_match_counter.sv
// Scoreboard bench: overlap (a) and non-overlap (b) instances of pattern_match_counter.
// Pattern-load vectors run when PATTERN_LOAD_EN is defined.
module tb_pattern_match_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_bit = 1'b0;
  logic       clear = 1'b0;
  logic       vld_a = 1'b0;
  logic       vld_b = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0110;

  logic       match_a, match_b, ovf_a, ovf_b;
  logic [3:0] count_a, count_b;
  logic [7:0] seg_a, seg_b;

  always #5 clk = ~clk;

  pattern_match_counter #(.OVERLAP(1'b1)) dut_a (
    .clk_2(clk), .reset(reset), .in_valid(vld_a),
    .in_bit(in_bit), .clear(clear),
`ifdef PATTERN_LOAD_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .match(match_a), .count(count_a),
    .overflow(ovf_a), .seg(seg_a)
  );

  pattern_match_counter #(.OVERLAP(1'b0)) dut_b (
    .clk_2(clk), .reset(reset), .in_valid(vld_b),
    .in_bit(in_bit), .clear(clear),
`ifdef PATTERN_LOAD_EN
    .pat_load(1'b0), .pat_in(4'b1011),
`endif
    .match(match_b), .count(count_b),
    .overflow(ovf_b), .seg(seg_b)
  );

  typedef struct {
    logic       ma;
    logic [3:0] ca;
    logic       oa;
    logic       mb;
    logic [3:0] cb;
    logic       ob;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   en_a = 1'b1;
  bit   en_b = 1'b0;
  logic [3:0] cnt_a = '0, cnt_b = '0;
  logic       of_a = 1'b0, of_b = 1'b0;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                           7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h58, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; ma/mb are the hand-derived match pulses.
  task automatic step(input bit v, input bit b, input bit c,
                      input bit ld, input bit ma, input bit mb);
    exp_t e;
    @(negedge clk);
    vld_a    = v & en_a;
    vld_b    = v & en_b;
    in_bit   = b;
    clear    = c;
    pat_load = ld;
    if (c) begin
      cnt_a = '0; of_a = 1'b0;
      cnt_b = '0; of_b = 1'b0;
    end else begin
      if (ma) begin
        if (cnt_a == 4'hF) of_a = 1'b1;
        cnt_a = cnt_a + 1'b1;
      end
      if (mb) begin
        if (cnt_b == 4'hF) of_b = 1'b1;
        cnt_b = cnt_b + 1'b1;
      end
    end
    e = '{ma, cnt_a, of_a, mb, cnt_b, of_b};
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      chk("match_a", 8'(match_a), 8'(e.ma));
      chk("count_a", 8'(count_a), 8'(e.ca));
      chk("seg_a", seg_a, {e.oa, glyph(e.ca)});
      chk("match_b", 8'(match_b), 8'(e.mb));
      chk("count_b", 8'(count_b), 8'(e.cb));
      chk("seg_b", seg_b, {e.ob, glyph(e.cb)});
    end
  end

  initial begin
    logic [6:0] s2 = 7'b1011011;
    logic [6:0] m2 = 7'b0001001;
    logic [6:0] m3 = 7'b0001000;
    #1;
    chk("rst_match", 8'(match_a), 8'h00);
    chk("rst_count", 8'(count_a), 8'h00);
    chk("rst_ovf", 8'(ovf_a), 8'h00);
    chk("rst_seg", seg_a, 8'h3F);
    @(negedge clk);
    reset = 1'b0;

    // Overlapping stream: hits after bits 4 and 7.
    for (int i = 6; i >= 0; i--)
      step(1, s2[i], 0, 0, m2[i], 0);
    // Same stream with 3-cycle valid gaps; history 011 gives same hits.
    for (int i = 6; i >= 0; i--) begin
      step(1, s2[i], 0, 0, m2[i], 0);
      idle(3);
    end
    chk("gap_total", 8'(cnt_a), 8'h04);

    // Partial 1,0,1 then asynchronous reset between edges.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    idle(1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_match", 8'(match_a), 8'h00);
    chk("arst_count", 8'(count_a), 8'h00);
    chk("arst_ovf", 8'(ovf_a), 8'h00);
    chk("arst_seg", seg_a, 8'h3F);
    cnt_a = '0; of_a = 1'b0;
    cnt_b = '0; of_b = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    // Non-overlap instance only: one hit, then appended 1 misses.
    en_a = 1'b0;
    en_b = 1'b1;
    for (int i = 6; i >= 0; i--)
      step(1, s2[i], 0, 0, 0, m3[i]);
    step(1, 1, 0, 0, 0, 0);
    idle(1);
    chk("noovl_seg", seg_b, 8'h06);

    // Overlap instance: 16 hits wrap the counter.
    en_a = 1'b1;
    en_b = 1'b0;
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    for (int g = 0; g < 15; g++) begin
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0);
    end
    idle(1);
    chk("wrap_seg", seg_a, 8'hBF);
    // 17th hit coincides with clear.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    idle(2);

`ifdef PATTERN_LOAD_EN
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    idle(2);
`endif

    idle(1);
    @(negedge clk);
    @(negedge clk);
    chk("drain", 8'(q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pattern_match_counter.md
Name: pattern_match_counter

Overview:
- Parametrised successor to the board-level hex counter and fixed "111" sequence detector.
- Detects a configurable serial bit pattern, with overlap selectable, and counts the matches in a wrapping counter of parametrised width.
- Drives a 7-segment display with the low hex digit of the count; overflow is shown on the decimal point.
- Sits between the SWI/clock inputs and the SEG/LED outputs of the top level.

Parameters:
PAT_LEN, 4, pattern length in bits (2..16)
PATTERN, 4'b1011, pattern to match; MSB is the first bit received
NBITS_COUNT, 4, match counter width (>=4)
OVERLAP, 1, 1 = overlapping matches allowed; 0 = detector restarts after each match

Ports:
clk_2  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  qualifies in_bit; a bit is accepted on a rising clk_2 edge with in_valid=1
in_bit  in  1  serial data bit
clear  in  1  synchronous clear of count and overflow
match  out  1  one-cycle pulse, registered, for each detected pattern
count  out  NBITS_COUNT  number of matches, modulo 2^NBITS_COUNT
overflow  out  1  sticky flag, set when count wraps
seg  out  8  7-segment code {dp,g,f,e,d,c,b,a}, active-high

Behaviour:
- Reset (asynchronous, active-high), applies to all registers:
  - hist=0, fill=0, match=0, count=0, overflow=0.
  - seg=8'h3F. Reset mid-stream discards any partial pattern.
- History:
  - hist is a PAT_LEN-1 bit shift register; fill is a saturating count, 0..PAT_LEN-1, of valid bits held in hist.
  - On an accepted bit: hist <= {hist[PAT_LEN-3:0], in_bit}; fill <= min(fill+1, PAT_LEN-1).
  - in_valid=0: hist, fill and count hold; match <= 0.
- Detection on an accepted bit:
  - hit = (fill==PAT_LEN-1) && ({hist, in_bit}==PATTERN).
  - hit: match <= 1 on that edge, visible the next cycle for exactly one cycle.
  - If OVERLAP=0, fill <= 0 on a hit, so the next match needs PAT_LEN fresh bits.
  - If OVERLAP=1, the hit does not affect fill.
- Counter:
  - Increments on the same edge that sets match, so count and match are both visible one cycle after the completing bit.
  - Wraps from all-ones to 0; the wrap sets overflow, which stays set until clear or reset.
- clear:
  - Synchronous. count <= 0, overflow <= 0.
  - Has priority over a simultaneous increment (count=0, not 1).
  - match still pulses for a hit in the same cycle.
  - Detector history is unaffected.
- seg:
  - Combinational from the registers.
  - seg[6:0] = hex glyph of count[3:0]: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:58 D:5E E:79 F:71.
  - seg[7] = overflow.
- Latency: completing bit accepted at edge N; match, count and seg all reflect the hit after edge N.

Optional Feature:
- Macro PATTERN_LOAD_EN.
- When defined, two ports are added:
  - pat_load  in  1
  - pat_in  in  PAT_LEN
- The active pattern is a register, reset value PATTERN.
- pat_load=1 at an edge: pattern <= pat_in and fill <= 0. Any bit accepted in that same cycle is ignored, and no match is generated that cycle.
- When the macro is undefined, the ports are absent and the pattern is the constant PATTERN.

Test Plan:
1. Reset asserted asynchronously between clock edges mid-pattern -> match=0, count=0, overflow=0, seg=8'h3F immediately. Feeding 0,1,1 after release gives no match.
2. OVERLAP=1, PATTERN=1011, bits 1,0,1,1,0,1,1 with in_valid=1 -> match pulses after bits 4 and 7; final count=2, seg=8'h5B.
3. OVERLAP=0, same stream -> single match after bit 4; count=1, seg=8'h06. Appending bit 1 (stream now 0,1,1,1 since restart) gives no match.
4. Same stream as scenario 2 with in_valid=0 gaps of 3 cycles between bits -> identical match/count results; match is never high during a gap and never wider than one cycle.
5. 16 matches (NBITS_COUNT=4) -> count=0, overflow=1, seg=8'hBF. Then clear asserted in the same cycle as a 17th hit -> count=0, overflow=0, match=1 for one cycle.
6. PATTERN_LOAD_EN defined: pat_load with pat_in=4'b0110 while 3 bits of 1011 are held -> fill cleared. Stream 1,0,1,1 gives no match; 0,1,1,0 gives match, count +1.
